// File: rtl/maq_pkg.sv
// Shared types and BCD hour arithmetic for the clock stages.
package maq_pkg;

    localparam int unsigned UNI_W = 4;
    localparam int unsigned DEZ_W = 2;

    typedef struct packed {
        logic [UNI_W-1:0] uni;
        logic [DEZ_W-1:0] dez;
    } hora_t;

    // Binary value of a BCD tens/units pair.
    function automatic int unsigned bcd_val(input logic [UNI_W-1:0] uni,
                                            input logic [DEZ_W-1:0] dez);
        return 32'(dez) * 32'd10 + 32'(uni);
    endfunction

    // Increment, wrapping max -> 00.
    function automatic hora_t bcd_inc(input logic [UNI_W-1:0] uni,
                                      input logic [DEZ_W-1:0] dez,
                                      input int unsigned      max);
        hora_t r;
        if (bcd_val(uni, dez) == max) begin
            r.uni = '0;
            r.dez = '0;
        end else if (uni == 4'd9) begin
            r.uni = '0;
            r.dez = dez + 2'd1;
        end else begin
            r.uni = uni + 4'd1;
            r.dez = dez;
        end
        return r;
    endfunction

    // Decrement, wrapping 00 -> max.
    function automatic hora_t bcd_dec(input logic [UNI_W-1:0] uni,
                                      input logic [DEZ_W-1:0] dez,
                                      input int unsigned      max);
        hora_t r;
        if (bcd_val(uni, dez) == 0) begin
            r.uni = 4'(max % 32'd10);
            r.dez = 2'(max / 32'd10);
        end else if (uni == 4'd0) begin
            r.uni = 4'd9;
            r.dez = dez - 2'd1;
        end else begin
            r.uni = uni - 4'd1;
            r.dez = dez;
        end
        return r;
    endfunction

endpackage

// File: rtl/maq_h_btn_edge.sv
// Button synchroniser plus rising-edge detector: one pulse per press.
module btn_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   s;

    assign s     = sync_q[SYNC_STAGES-1];
    assign pulse = s & ~prev_q;

    // Synchroniser shift, plus a fill marker so prev stays 1 until the chain
    // holds post-reset samples; a button held through reset then never pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            fill_q <= '0;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= fill_q[SYNC_STAGES-1] ? s : 1'b1;
        end
    end

endmodule

// File: rtl/maq_h.sv
// Hours stage: BCD hour counter with minutes carry, day carry and manual set.
module maq_h
    import maq_pkg::*;
#(
    parameter int unsigned HOURS_MAX   = 23,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             maqh_clock,
    input  logic             maqh_reset,
    input  logic             maqh_enable,
    input  logic             maqh_add_hor,
    input  logic             maqh_set_mode,
    input  logic             maqh_btn_up,
    input  logic             maqh_btn_down,
    output logic [UNI_W-1:0] maqh_uni,
    output logic [DEZ_W-1:0] maqh_dez,
    output logic             maqh_add_dia
);

    hora_t hora_q;
    hora_t hora_d;
    logic  up_pulse;
    logic  down_pulse;
    logic  at_max;
    logic  count_ev;

    btn_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_btn_up (
        .clock(maqh_clock),
        .reset(maqh_reset),
        .raw  (maqh_btn_up),
        .pulse(up_pulse)
    );

    btn_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_btn_down (
        .clock(maqh_clock),
        .reset(maqh_reset),
        .raw  (maqh_btn_down),
        .pulse(down_pulse)
    );

    assign at_max       = (bcd_val(hora_q.uni, hora_q.dez) == HOURS_MAX);
    assign count_ev     = maqh_enable & ~maqh_set_mode & maqh_add_hor;
    // Adjust wraps go through hora_d only, so they never raise the day carry.
    assign maqh_add_dia = count_ev & at_max & ~maqh_reset;

    // Next hour: carry in run mode, single-step buttons in set mode.
    always_comb begin
        hora_d = hora_q;
        if (maqh_enable) begin
            if (!maqh_set_mode) begin
                if (maqh_add_hor) begin
                    hora_d = bcd_inc(hora_q.uni, hora_q.dez, HOURS_MAX);
                end
            end else if (up_pulse && !down_pulse) begin
                hora_d = bcd_inc(hora_q.uni, hora_q.dez, HOURS_MAX);
            end else if (down_pulse && !up_pulse) begin
                hora_d = bcd_dec(hora_q.uni, hora_q.dez, HOURS_MAX);
            end
        end
    end

    // Hour register; reset wins over any same-edge event.
    always_ff @(posedge maqh_clock) begin
        if (maqh_reset) begin
            hora_q <= '0;
        end else begin
            hora_q <= hora_d;
        end
    end

    assign maqh_uni = hora_q.uni;
    assign maqh_dez = hora_q.dez;

endmodule

// File: tb/tb_maq_h.sv
// Directed self-checking bench for the hours stage.
module tb_maq_h;

    logic       clk = 1'b0;
    logic       rst, en, add, setm, bup, bdn;
    logic [3:0] uni;
    logic [1:0] dez;
    logic       dia;

    logic       rst2, en2, add2, setm2, bup2, bdn2;
    logic [3:0] uni2;
    logic [1:0] dez2;
    logic       dia2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    maq_h #(
        .HOURS_MAX  (23),
        .SYNC_STAGES(2)
    ) dut (
        .maqh_clock   (clk),
        .maqh_reset   (rst),
        .maqh_enable  (en),
        .maqh_add_hor (add),
        .maqh_set_mode(setm),
        .maqh_btn_up  (bup),
        .maqh_btn_down(bdn),
        .maqh_uni     (uni),
        .maqh_dez     (dez),
        .maqh_add_dia (dia)
    );

    maq_h #(
        .HOURS_MAX  (2),
        .SYNC_STAGES(2)
    ) dut2 (
        .maqh_clock   (clk),
        .maqh_reset   (rst2),
        .maqh_enable  (en2),
        .maqh_add_hor (add2),
        .maqh_set_mode(setm2),
        .maqh_btn_up  (bup2),
        .maqh_btn_down(bdn2),
        .maqh_uni     (uni2),
        .maqh_dez     (dez2),
        .maqh_add_dia (dia2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up);
        if (up) bup = 1'b1; else bdn = 1'b1;
        tick();
        tick();
        bup = 1'b0;
        bdn = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; add = 1'b0; setm = 1'b0; bup = 1'b0; bdn = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({dez, uni, dia} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_state got dez=%0d uni=%0d dia=%0b want 0 0 0", dez, uni, dia);
        end
        // Button held high through reset release must not step the hour.
        bup = 1'b1; setm = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if ({dez, uni} !== 6'd0) begin
                tests_failed++;
                $display("FAIL held_btn_reset cyc=%0d got %0d%0d want 00", i, dez, uni);
            end
        end
        bup = 1'b0;
        repeat (4) tick();
        setm = 1'b0;
    endtask

    task automatic test_count();
        logic [1:0] ed;
        logic [3:0] eu;
        for (int i = 1; i <= 23; i++) begin
            add = 1'b1;
            tick();
            add = 1'b0;
            ed = 2'(i / 10);
            eu = 4'(i % 10);
            tests_run++;
            if (dez !== ed || uni !== eu) begin
                tests_failed++;
                $display("FAIL count step=%0d got %0d%0d want %0d%0d", i, dez, uni, ed, eu);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        en = 1'b0; add = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({dez, uni} !== {2'd2, 4'd3} || dia !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_disabled cyc=%0d got %0d%0d dia=%0b want 23 dia=0",
                         i, dez, uni, dia);
            end
        end
        en = 1'b1; setm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({dez, uni} !== {2'd2, 4'd3} || dia !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_setmode cyc=%0d got %0d%0d dia=%0b want 23 dia=0",
                         i, dez, uni, dia);
            end
        end
        add = 1'b0; setm = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        add = 1'b1;
        #1;
        tests_run++;
        if (dia !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_carry got dia=%0b want 1", dia);
        end
        tick();
        tests_run++;
        if ({dez, uni} !== 6'd0 || dia !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_value got %0d%0d dia=%0b want 00 dia=0", dez, uni, dia);
        end
        add = 1'b0;
        tick();
    endtask

    task automatic test_adjust();
        logic [3:0] eu;
        setm = 1'b1;
        bdn = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({dez, uni} !== 6'd0) begin
            tests_failed++;
            $display("FAIL down_latency got %0d%0d want 00 after one edge", dez, uni);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({dez, uni} !== {2'd2, 4'd3} || dia !== 1'b0) begin
                tests_failed++;
                $display("FAIL down_wrap cyc=%0d got %0d%0d dia=%0b want 23 dia=0",
                         i, dez, uni, dia);
            end
            tick();
        end
        bdn = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            press(1'b1);
            eu = 4'(i);
            tests_run++;
            if ({dez, uni} !== {2'd0, eu} || dia !== 1'b0) begin
                tests_failed++;
                $display("FAIL up_press n=%0d got %0d%0d dia=%0b want 0%0d dia=0",
                         i, dez, uni, dia, eu);
            end
        end
    endtask

    task automatic test_simultaneous();
        bup = 1'b1; bdn = 1'b1;
        repeat (3) tick();
        bup = 1'b0; bdn = 1'b0;
        repeat (4) tick();
        tests_run++;
        if ({dez, uni} !== {2'd0, 4'd2}) begin
            tests_failed++;
            $display("FAIL both_buttons got %0d%0d want 02", dez, uni);
        end
        repeat (8) press(1'b1);
        tests_run++;
        if ({dez, uni} !== {2'd1, 4'd0}) begin
            tests_failed++;
            $display("FAIL up_to_10 got %0d%0d want 10", dez, uni);
        end
        press(1'b0);
        tests_run++;
        if ({dez, uni} !== {2'd0, 4'd9}) begin
            tests_failed++;
            $display("FAIL down_10_to_09 got %0d%0d want 09", dez, uni);
        end
        setm = 1'b0;
    endtask

    task automatic test_short_max();
        logic [3:0] exp_tbl [3];
        logic       edia;
        exp_tbl[0] = 4'd1; exp_tbl[1] = 4'd2; exp_tbl[2] = 4'd0;
        en2 = 1'b1; add2 = 1'b0;
        tick();
        rst2 = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            add2 = 1'b1;
            #1;
            edia = (j == 2);
            tests_run++;
            if (dia2 !== edia) begin
                tests_failed++;
                $display("FAIL short_carry n=%0d got dia=%0b want %0b", j, dia2, edia);
            end
            tick();
            add2 = 1'b0;
            tests_run++;
            if ({dez2, uni2} !== {2'd0, exp_tbl[j]}) begin
                tests_failed++;
                $display("FAIL short_count n=%0d got %0d%0d want 0%0d",
                         j, dez2, uni2, exp_tbl[j]);
            end
            tick();
        end
        add2 = 1'b1;
        tick();
        add2 = 1'b0;
        tick();
        add2 = 1'b1; rst2 = 1'b1;
        tick();
        tests_run++;
        if ({dez2, uni2} !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_vs_count got %0d%0d want 00", dez2, uni2);
        end
        // At H=max, reset must gate the day carry.
        rst2 = 1'b0; add2 = 1'b0;
        tick();
        repeat (2) begin
            add2 = 1'b1;
            tick();
            add2 = 1'b0;
            tick();
        end
        add2 = 1'b1; rst2 = 1'b1;
        #1;
        tests_run++;
        if (dia2 !== 1'b0 || {dez2, uni2} !== {2'd0, 4'd2}) begin
            tests_failed++;
            $display("FAIL reset_gates_carry got %0d%0d dia=%0b want 02 dia=0",
                     dez2, uni2, dia2);
        end
        tick();
        tests_run++;
        if ({dez2, uni2} !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_at_max got %0d%0d want 00", dez2, uni2);
        end
        add2 = 1'b0;
    endtask

    initial begin
        rst2 = 1'b1; en2 = 1'b0; add2 = 1'b0; setm2 = 1'b0; bup2 = 1'b0; bdn2 = 1'b0;
        test_reset();
        test_count();
        test_hold();
        test_wrap();
        test_adjust();
        test_simultaneous();
        test_short_max();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
